// File: rtl/imu_poll_pkg.sv
// Shared types and default constants for the IMU polling sequencer.
// The optional response watchdog in the top level is enabled with the
// macro IMU_POLL_TIMEOUT_EN.
package imu_poll_pkg;

  // State encoding width and frame index width. The index width covers up to 16 registers.
  localparam int STATE_W = 3;
  localparam int IDX_W   = 4;

  // Default parameter values for the sequencer.
  localparam int unsigned DEF_N_REGS      = 6;
  localparam int unsigned DEF_POLL_DIV    = 100000;
  localparam logic [6:0]  DEF_SLAVE_ADDR  = 7'h68;
  localparam logic [7:0]  DEF_BASE_REG    = 8'h3B;
  localparam int unsigned DEF_MAX_RETRY   = 2;
  localparam int unsigned DEF_TIMEOUT_CYC = 4096;

  // Sequencer states.
  typedef enum logic [STATE_W-1:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    ISSUE     = 3'd2,
    WAIT_RSP  = 3'd3,
    RETRY     = 3'd4,
    PUBLISH   = 3'd5,
    FAULT     = 3'd6
  } state_t;

  // Increment a 16-bit counter that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/poll_tick_gen.sv
// Free-running divider that emits a one-cycle tick every POLL_DIV clocks.
// It runs regardless of what the sequencer is doing, so frame starts stay
// on a fixed cadence even when a frame overruns and a tick is dropped.
module poll_tick_gen #(
  parameter int unsigned POLL_DIV = imu_poll_pkg::DEF_POLL_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CNT_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(POLL_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Count 0..POLL_DIV-1 and register a tick on the wrap cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CNT_W'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/imu_poll_sequencer.sv
// Periodically reads N_REGS consecutive registers from an I2C IMU through a
// single-byte-read command interface, retries failed bytes, and publishes a
// complete frame as one sample. Repeated failures latch a sticky fault.
// Optional: define IMU_POLL_TIMEOUT_EN to add a response watchdog that
// treats TIMEOUT_CYC silent cycles in WAIT_RSP as an error response.
module imu_poll_sequencer
  import imu_poll_pkg::*;
#(
  parameter int unsigned N_REGS      = DEF_N_REGS,
  parameter int unsigned POLL_DIV    = DEF_POLL_DIV,
  parameter logic [6:0]  SLAVE_ADDR  = DEF_SLAVE_ADDR,
  parameter logic [7:0]  BASE_REG    = DEF_BASE_REG,
  parameter int unsigned MAX_RETRY   = DEF_MAX_RETRY,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [6:0]            cmd_slave_addr,
  output logic [7:0]            cmd_reg_addr,
  input  logic                  rsp_valid,
  input  logic [7:0]            rsp_data,
  input  logic                  rsp_err,
  output logic                  sample_valid,
  output logic [8*N_REGS-1:0]   sample_data,
  output logic                  busy,
  output logic                  fault,
  output logic [15:0]           err_count
);

  localparam logic [7:0]       MAX_RETRY_B = 8'(MAX_RETRY);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_REGS - 1);

  state_t              state;
  state_t              next_state;
  logic                tick;
  logic [IDX_W-1:0]    idx;
  logic [7:0]          retry_cnt;
  logic [8*N_REGS-1:0] shadow;
  logic [8*N_REGS-1:0] shadow_upd;
  logic                rsp_ok;
  logic                rsp_fail;
  logic                last_byte;
  logic                timeout_hit;

  poll_tick_gen #(
    .POLL_DIV (POLL_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Responses only count while a command is outstanding; anything else is stale.
  assign rsp_ok    = (state == WAIT_RSP) && rsp_valid && !rsp_err;
  assign rsp_fail  = (state == WAIT_RSP) && ((rsp_valid && rsp_err) || timeout_hit);
  assign last_byte = (idx == LAST_IDX);

`ifdef IMU_POLL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt;

  // Watchdog counts cycles spent waiting for the current response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (state != WAIT_RSP) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  assign timeout_hit = (state == WAIT_RSP) && !rsp_valid &&
                       (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout_cfg;
  assign timeout_hit        = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

  // Shadow buffer with the incoming byte merged into the current index slot.
  always_comb begin
    shadow_upd = shadow;
    for (int k = 0; k < int'(N_REGS); k++) begin
      if (idx == IDX_W'(k)) begin
        shadow_upd[8*k +: 8] = rsp_data;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    next_state     = state;
    cmd_valid      = 1'b0;
    busy           = 1'b0;
    fault          = 1'b0;
    cmd_slave_addr = SLAVE_ADDR;
    cmd_reg_addr   = BASE_REG + 8'(idx);
    case (state)
      IDLE: begin
        if (enable) next_state = WAIT_TICK;
      end
      WAIT_TICK: begin
        if (!enable)   next_state = IDLE;
        else if (tick) next_state = ISSUE;
      end
      ISSUE: begin
        cmd_valid = 1'b1;
        busy      = 1'b1;
        if (cmd_ready) next_state = WAIT_RSP;
      end
      WAIT_RSP: begin
        busy = 1'b1;
        if (rsp_ok)        next_state = last_byte ? PUBLISH : ISSUE;
        else if (rsp_fail) next_state = RETRY;
      end
      RETRY: begin
        busy = 1'b1;
        if (!enable)                     next_state = IDLE;
        else if (retry_cnt < MAX_RETRY_B) next_state = ISSUE;
        else                             next_state = FAULT;
      end
      PUBLISH: begin
        busy       = 1'b1;
        next_state = enable ? WAIT_TICK : IDLE;
      end
      FAULT: begin
        fault      = 1'b1;
        next_state = FAULT;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Frame datapath: byte index, retry budget, shadow capture, publish and error count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx          <= '0;
      retry_cnt    <= '0;
      shadow       <= '0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
      err_count    <= '0;
    end else begin
      sample_valid <= rsp_ok && last_byte;
      if (state == WAIT_TICK && next_state == ISSUE) begin
        idx       <= '0;
        retry_cnt <= '0;
      end
      if (rsp_ok) begin
        shadow    <= shadow_upd;
        retry_cnt <= '0;
        if (last_byte) begin
          sample_data <= shadow_upd;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
      if (rsp_fail) begin
        err_count <= sat_inc16(err_count);
      end
      if (state == RETRY && next_state == ISSUE) begin
        retry_cnt <= retry_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_imu_poll_sequencer.sv
// Scoreboard bench for imu_poll_sequencer. A behavioural I2C master answers
// commands, builds the expected frame from the bytes it returns, and queues
// it; frames published by the sequencer are popped and compared.
// Honours IMU_POLL_TIMEOUT_EN to pick the watchdog expectation.
module tb_imu_poll_sequencer;

  localparam int NR = 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            enable;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [6:0]      cmd_slave_addr;
  logic [7:0]      cmd_reg_addr;
  logic            rsp_valid;
  logic [7:0]      rsp_data;
  logic            rsp_err;
  logic            sample_valid;
  logic [8*NR-1:0] sample_data;
  logic            busy;
  logic            fault;
  logic [15:0]     err_count;

  imu_poll_sequencer #(
    .N_REGS      (NR),
    .POLL_DIV    (64),
    .SLAVE_ADDR  (7'h68),
    .BASE_REG    (8'h3B),
    .MAX_RETRY   (2),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_slave_addr (cmd_slave_addr),
    .cmd_reg_addr   (cmd_reg_addr),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err),
    .sample_valid   (sample_valid),
    .sample_data    (sample_data),
    .busy           (busy),
    .fault          (fault),
    .err_count      (err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Responder configuration and model state.
  logic [7:0]      salt = 8'h00;
  int              ready_hold = 0;
  bit              mute = 1'b0;
  int              err_plan [16];
  int              stall_idx = -1;
  int              model_idx = 0;
  logic [8*NR-1:0] model_shadow = '0;
  logic [8*NR-1:0] exp_q [$];
  int              resp_cnt = -1;
  int              resp_idx = 0;
  bit              resp_stale = 1'b0;
  int              handshakes = 0;
  int              samples = 0;
  bit              lat_chk = 1'b0;
  bit              holding = 1'b0;
  logic [7:0]      hold_addr = 8'h00;
  logic [8*NR-1:0] last_sample = '0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] s, input int hold, input int err_idx,
                               input int err_n, input int stall, input bit quiet);
    salt       = s;
    ready_hold = hold;
    stall_idx  = stall;
    mute       = quiet;
    for (int i = 0; i < 16; i++) err_plan[i] = 0;
    if (err_idx >= 0) err_plan[err_idx] = err_n;
  endtask

  task automatic waitSamples(input int target, input int budget);
    int n = 0;
    while (samples < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("frame_done", 64'(samples), 64'(target));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_cmd_valid"},    64'(cmd_valid),    64'd0);
    checkOutput({tag, "_cmd_reg_addr"}, 64'(cmd_reg_addr), 64'h3B);
    checkOutput({tag, "_sample_valid"}, 64'(sample_valid), 64'd0);
    checkOutput({tag, "_sample_data"},  64'(sample_data),  64'd0);
    checkOutput({tag, "_busy"},         64'(busy),         64'd0);
    checkOutput({tag, "_fault"},        64'(fault),        64'd0);
    checkOutput({tag, "_err_count"},    64'(err_count),    64'd0);
  endtask

  // Behavioural I2C master: accepts commands, answers them, and feeds the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_err   = 1'b0;
      rsp_data  = 8'h00;
      model_idx    = 0;
      model_shadow = '0;
      lat_chk      = 1'b0;
      holding      = 1'b0;
      if (resp_cnt >= 0) resp_stale = 1'b1;
      if (sample_valid) checkOutput("sample_in_reset", 64'(sample_valid), 64'd0);
    end else begin
      if (lat_chk) begin
        checkOutput("latency", 64'(sample_valid), 64'd1);
        lat_chk = 1'b0;
      end
      if (sample_valid) begin
        samples++;
        last_sample = sample_data;
        if (exp_q.size() == 0) checkOutput("unexpected_sample", 64'(sample_valid), 64'd0);
        else checkOutput("sample_data", 64'(sample_data), 64'(exp_q.pop_front()));
      end
      rsp_valid = 1'b0;
      rsp_err   = 1'b0;
      cmd_ready = 1'b0;
      if (holding && !cmd_valid) begin
        checkOutput("cmd_valid_held", 64'(cmd_valid), 64'd1);
        holding = 1'b0;
      end
      if (resp_cnt > 0) begin
        resp_cnt--;
      end else if (resp_cnt == 0) begin
        resp_cnt  = -1;
        rsp_valid = 1'b1;
        if (resp_stale) begin
          rsp_data   = 8'hEE;
          resp_stale = 1'b0;
        end else if (err_plan[resp_idx] > 0) begin
          rsp_err  = 1'b1;
          rsp_data = 8'hFF;
          err_plan[resp_idx]--;
        end else begin
          rsp_data = 8'(8'h10 + resp_idx + int'(salt));
          model_shadow[resp_idx*8 +: 8] = rsp_data;
          if (resp_idx == NR - 1) begin
            exp_q.push_back(model_shadow);
            lat_chk   = 1'b1;
            model_idx = 0;
          end else begin
            model_idx++;
          end
        end
      end else if (cmd_valid) begin
        if (ready_hold > 0) begin
          if (!holding) begin
            holding   = 1'b1;
            hold_addr = cmd_reg_addr;
          end else begin
            checkOutput("cmd_stable", 64'(cmd_reg_addr), 64'(hold_addr));
          end
          ready_hold--;
        end else begin
          cmd_ready = 1'b1;
          handshakes++;
          holding = 1'b0;
          checkOutput("cmd_addr", 64'(cmd_reg_addr), 64'(8'(8'h3B + model_idx)));
          checkOutput("slave_addr", 64'(cmd_slave_addr), 64'h68);
          resp_idx   = model_idx;
          resp_stale = 1'b0;
          resp_cnt   = mute ? -1 : ((model_idx == stall_idx) ? 12 : 2);
        end
      end
    end
  end

  int hs;
  int s0;
  int n;

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b0;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_data  = 8'h00;
    for (int i = 0; i < 16; i++) err_plan[i] = 0;
    #23;
    checkResetOutputs("por");
    @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;

    // Plain frame: bytes 10..15.
    applyStimulus(8'h00, 0, -1, 0, -1, 1'b0);
    hs = handshakes;
    waitSamples(1, 400);
    checkOutput("frame1_value", 64'(last_sample), 64'h151413121110);
    checkOutput("frame1_cmds", 64'(handshakes - hs), 64'd6);

    // Back-pressure on the first command.
    applyStimulus(8'h20, 20, -1, 0, -1, 1'b0);
    hs = handshakes;
    waitSamples(2, 400);
    checkOutput("frame2_value", 64'(last_sample), 64'h353433323130);
    checkOutput("frame2_cmds", 64'(handshakes - hs), 64'd6);

    // One error on index 2 causes a single reissue of 3D.
    applyStimulus(8'h40, 0, 2, 1, -1, 1'b0);
    hs = handshakes;
    waitSamples(3, 400);
    checkOutput("frame3_value", 64'(last_sample), 64'h555453525150);
    checkOutput("frame3_cmds", 64'(handshakes - hs), 64'd7);
    checkOutput("frame3_err_count", 64'(err_count), 64'd1);

    // Reset while waiting on index 3; stale response lands after release.
    applyStimulus(8'h60, 0, -1, 0, 3, 1'b0);
    n = 0;
    while (!(model_idx == 3 && resp_cnt > 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reach_idx3", 64'(model_idx), 64'd3);
    repeat (3) @(negedge clk);
    checkOutput("busy_before_reset", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midrst");
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    stall_idx = -1;
    s0 = samples;
    waitSamples(s0 + 1, 400);
    checkOutput("post_reset_value", 64'(last_sample), 64'h757473727170);

    // Three errors on index 0 exhaust the retries.
    applyStimulus(8'h00, 0, 0, 3, -1, 1'b0);
    hs = handshakes;
    s0 = samples;
    n  = 0;
    while (!fault && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput("fault_set", 64'(fault), 64'd1);
    repeat (200) @(negedge clk);
    checkOutput("fault_sticky", 64'(fault), 64'd1);
    checkOutput("fault_cmd_valid", 64'(cmd_valid), 64'd0);
    checkOutput("fault_busy", 64'(busy), 64'd0);
    checkOutput("fault_err_count", 64'(err_count), 64'd3);
    checkOutput("fault_no_sample", 64'(samples - s0), 64'd0);
    checkOutput("fault_cmds", 64'(handshakes - hs), 64'd3);
    rst_n = 1'b0;
    #1;
    checkOutput("fault_cleared", 64'(fault), 64'd0);
    checkOutput("fault_err_cleared", 64'(err_count), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'h80, 0, -1, 0, -1, 1'b0);
    s0 = samples;
    waitSamples(s0 + 1, 400);
    checkOutput("recover_value", 64'(last_sample), 64'h959493929190);

    // Silent responder: watchdog behaviour depends on the build.
    applyStimulus(8'h00, 0, -1, 0, -1, 1'b1);
    hs = handshakes;
    n  = 0;
    while (handshakes == hs && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("silent_first_cmd", 64'(handshakes - hs), 64'd1);
`ifdef IMU_POLL_TIMEOUT_EN
    repeat (25) @(negedge clk);
    checkOutput("timeout_err_count", 64'(err_count), 64'd1);
    checkOutput("timeout_reissue", 64'(handshakes - hs), 64'd2);
`else
    repeat (10000) @(negedge clk);
    checkOutput("no_wd_err_count", 64'(err_count), 64'd0);
    checkOutput("no_wd_cmds", 64'(handshakes - hs), 64'd1);
    checkOutput("no_wd_busy", 64'(busy), 64'd1);
`endif
    mute  = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imu_poll_sequencer.md
IMU_POLL_SEQUENCER -- requirements
Module: imu_poll_sequencer

Interface
REQ-001 SHALL have parameter N_REGS, default 6, number of consecutive registers read per frame (1..16).
REQ-002 SHALL have parameter POLL_DIV, default 100000, clk cycles between frame starts (>= 64).
REQ-003 SHALL have parameter SLAVE_ADDR, default 7'h68, 7-bit I2C target address.
REQ-004 SHALL have parameter BASE_REG, default 8'h3B, first register address of the frame.
REQ-005 SHALL have parameter MAX_RETRY, default 2, retries per byte after rsp_err.
REQ-006 SHALL have parameter TIMEOUT_CYC, default 4096, response watchdog limit (used only with REQ-030).
REQ-007 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port enable, input, 1, polling permitted.
REQ-010 SHALL have ports cmd_valid (output, 1), cmd_ready (input, 1), cmd_slave_addr (output, 7), and cmd_reg_addr (output, 8), forming the single-byte-read command to the I2C master.
REQ-011 SHALL have ports rsp_valid (input, 1), rsp_data (input, 8), and rsp_err (input, 1, NACK or bus error), forming the I2C master response.
REQ-012 SHALL have ports sample_valid (output, 1, one-cycle pulse) and sample_data (output, 8*N_REGS, byte k at bits [8k+7:8k]).
REQ-013 SHALL have ports busy (output, 1), fault (output, 1, sticky), and err_count (output, 16, saturating).

Function
REQ-014 SHALL implement states IDLE, WAIT_TICK, ISSUE, WAIT_RSP, RETRY, PUBLISH, FAULT.
REQ-015 SHALL run a free counter of POLL_DIV cycles, producing a one-cycle tick at wrap, independent of state.
REQ-016 SHALL transition IDLE->WAIT_TICK when enable=1; in any non-FAULT state, when enable=0 at a byte boundary (not in ISSUE/WAIT_RSP), go to IDLE.
REQ-017 SHALL transition WAIT_TICK->ISSUE on tick, clearing index to 0; a tick arriving while a frame is active is dropped (no queueing).
REQ-018 SHALL, in ISSUE, assert cmd_valid with cmd_reg_addr=BASE_REG+index (8-bit wrap) and hold the command stable until the cmd_valid&cmd_ready cycle, then go to WAIT_RSP.
REQ-019 SHALL, in WAIT_RSP on rsp_valid&!rsp_err, store rsp_data into byte[index] of a shadow buffer; if index==N_REGS-1 go to PUBLISH, else increment index and go to ISSUE.
REQ-020 SHALL, in WAIT_RSP on rsp_valid&rsp_err, increment err_count and go to RETRY; RETRY reissues the same index if retry_cnt<MAX_RETRY, else goes to FAULT.
REQ-021 SHALL reset retry_cnt to 0 on each successful byte.
REQ-022 SHALL, in PUBLISH, copy the shadow buffer to sample_data and pulse sample_valid for exactly one cycle, then go to WAIT_TICK; sample_data changes only in PUBLISH.
REQ-023 SHALL make FAULT sticky: fault=1, cmd_valid=0, exit only on reset.
REQ-024 SHALL drive busy=1 in ISSUE, WAIT_RSP, RETRY, and PUBLISH.
REQ-025 SHALL ignore rsp_valid outside WAIT_RSP.
REQ-026 SHALL saturate err_count at 16'hFFFF.
REQ-027 SHALL have a latency from the last good rsp_valid to sample_valid of 1 cycle.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force: state IDLE, cmd_valid 0, cmd_reg_addr BASE_REG, sample_valid 0, sample_data 0, busy 0, fault 0, err_count 0, and counters 0.
REQ-029 SHALL, on reset mid-transaction, abandon the frame without publishing; a stale rsp_valid after release is ignored per REQ-025.

Configuration
REQ-030 SHALL support macro IMU_POLL_TIMEOUT_EN: when defined, a watchdog in WAIT_RSP counts cycles and, at TIMEOUT_CYC without rsp_valid, behaves as rsp_err (REQ-020); when undefined, no watchdog exists and WAIT_RSP waits indefinitely.

Structure
REQ-031 SHALL place the state enum, default parameter constants, and the state encoding width in package imu_poll_pkg.
REQ-032 SHALL implement the POLL_DIV tick counter as sub-module poll_tick_gen (clk, rst_n, tick).

Verification
REQ-033 SHALL verify: N_REGS=6, responder returns 8'h10..8'h15 -> cmd_reg_addr 3B..40 in order, one sample_valid, sample_data=48'h151413121110.
REQ-034 SHALL verify: cmd_ready held low 20 cycles during ISSUE -> cmd_valid and cmd_reg_addr stable all 20 cycles, single accepted command.
REQ-035 SHALL verify: rsp_err once on index 2 -> reissue 8'h3D, err_count=1, frame still published.
REQ-036 SHALL verify: rsp_err three times on index 0 (MAX_RETRY=2) -> fault=1, cmd_valid=0 thereafter, no sample_valid until rst_n pulse.
REQ-037 SHALL verify: with IMU_POLL_TIMEOUT_EN, TIMEOUT_CYC=16, no response -> retry after 16 cycles, err_count=1; without the macro, no retry after 10000 cycles.
REQ-038 SHALL verify: rst_n asserted in WAIT_RSP at index 3 -> all outputs at reset values immediately, no sample_valid, clean frame after next tick.
